// File: rtl/flag_issue_ctrl.sv
// flag_issue_ctrl
//   Sequences the Z/C/S/O flag register around a multi-cycle ALU. An ALU op
//   is accepted through op_valid/op_ready. The controller then waits ALU_LAT
//   cycles and commits alu_flags into flags_q through a per-opcode write mask.
//   Branch-condition queries (br_req/br_ready) are evaluated against the
//   committed flags. They are interlocked against an op in flight.
//
// Optional feature macro: FLAG_FWD_EN
//   When defined, a query is also accepted in the final WAIT cycle. It is
//   evaluated on the merged (about-to-commit) flag value.
//
// Ports
//   clk        system clock, rising edge
//   r          asynchronous active-low reset
//   op_valid   ALU op issue request
//   op_ready   controller can accept an op this cycle
//   op_cond    ALU operation code, selects the flag write mask
//   alu_flags  ALU flag outputs, bit0=Z bit1=C bit2=S bit3=O
//   br_req     branch condition query
//   br_ready   query can be accepted this cycle
//   br_cond    branch condition select
//   br_valid   one-cycle pulse, br_taken is valid
//   br_taken   registered condition result (holds between queries)
//   flags_q    committed flags, same bit order as alu_flags
//   busy       op in flight
module flag_issue_ctrl #(
  parameter int ALU_LAT = 2
) (
  input  logic       clk,
  input  logic       r,
  input  logic       op_valid,
  output logic       op_ready,
  input  logic [4:0] op_cond,
  input  logic [3:0] alu_flags,
  input  logic       br_req,
  output logic       br_ready,
  input  logic [2:0] br_cond,
  output logic       br_valid,
  output logic       br_taken,
  output logic [3:0] flags_q,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;
  localparam logic [2:0] CNT_LOAD = 3'(ALU_LAT - 1);

  logic [0:0] state_reg;
  logic [2:0] cnt_reg;
  logic [3:0] mask_reg;
  logic [3:0] flags_reg;
  logic       br_valid_reg;
  logic       br_taken_reg;

  logic [3:0] merged_next;
  logic [3:0] eval_flags;
  logic       last_cycle;
  logic       op_fire;
  logic       br_fire;

  // Write mask per opcode, bit order O,S,C,Z (bit3..bit0).
  function automatic logic [3:0] mask_dec(input logic [4:0] c);
    logic [3:0] m;
    m = 4'b0000;
    case (c)
      5'b00000, 5'b00001, 5'b00011, 5'b00100,
      5'b00101, 5'b00110, 5'b01001:            m = 4'b1111;
      5'b01000:                                m = 4'b0111;
      5'b10000:                                m = 4'b0001;
      5'b01010, 5'b01011, 5'b10001, 5'b10100,
      5'b10101, 5'b10110, 5'b10111, 5'b11000,
      5'b11001, 5'b11010, 5'b11011, 5'b11100,
      5'b11101, 5'b11110:                      m = 4'b0101;
      default:                                 m = 4'b0000;
    endcase
    return m;
  endfunction

  function automatic logic cond_eval(input logic [2:0] sel, input logic [3:0] f);
    logic t;
    t = 1'b0;
    case (sel)
      3'b000: t = 1'b1;
      3'b001: t = f[0];
      3'b010: t = ~f[0];
      3'b011: t = f[1];
      3'b100: t = ~f[1];
      3'b101: t = f[2];
      3'b110: t = f[2] ^ f[3];
      3'b111: t = f[3];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  // Per-bit commit value: masked bits take the ALU flag, others hold.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_merge
      assign merged_next[gi] = mask_reg[gi] ? alu_flags[gi] : flags_reg[gi];
    end
  endgenerate

  assign last_cycle = (state_reg == WAIT) && (cnt_reg == 3'd0);

  // Branch has priority over an op issue in the same IDLE cycle.
  assign op_ready = (state_reg == IDLE) && !br_req;

`ifdef FLAG_FWD_EN
  assign br_ready   = (state_reg == IDLE) || last_cycle;
  assign eval_flags = last_cycle ? merged_next : flags_reg;
`else
  assign br_ready   = (state_reg == IDLE);
  assign eval_flags = flags_reg;
`endif

  assign op_fire = op_valid && op_ready;
  assign br_fire = br_req && br_ready;

  always_ff @(posedge clk or negedge r) begin
    if (!r) begin
      state_reg    <= IDLE;
      cnt_reg      <= 3'd0;
      mask_reg     <= 4'b0000;
      flags_reg    <= 4'b0000;
      br_valid_reg <= 1'b0;
      br_taken_reg <= 1'b0;
    end else begin
      br_valid_reg <= br_fire;
      if (br_fire) begin
        br_taken_reg <= cond_eval(br_cond, eval_flags);
      end

      case (state_reg)
        IDLE: begin
          if (op_fire) begin
            mask_reg  <= mask_dec(op_cond);
            cnt_reg   <= CNT_LOAD;
            state_reg <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_reg != 3'd0) begin
            cnt_reg <= cnt_reg - 3'd1;
          end else begin
            flags_reg <= merged_next;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign flags_q  = flags_reg;
  assign br_valid = br_valid_reg;
  assign br_taken = br_taken_reg;
  assign busy     = (state_reg != IDLE);

endmodule

// File: tb/tb_flag_issue_ctrl.sv
module tb_flag_issue_ctrl;

  logic       clk = 1'b0;
  logic       r = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [4:0] op_cond = 5'b00000;
  logic [3:0] alu_flags = 4'b0000;
  logic       br_req = 1'b0;
  logic       br_ready;
  logic [2:0] br_cond = 3'b000;
  logic       br_valid;
  logic       br_taken;
  logic [3:0] flags_q;
  logic       busy;

  int pass_cnt = 0;
  int total_cnt = 0;

  flag_issue_ctrl #(.ALU_LAT(2)) dut (
    .clk      (clk),
    .r        (r),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_cond  (op_cond),
    .alu_flags(alu_flags),
    .br_req   (br_req),
    .br_ready (br_ready),
    .br_cond  (br_cond),
    .br_valid (br_valid),
    .br_taken (br_taken),
    .flags_q  (flags_q),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total_cnt = total_cnt + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one op from IDLE with ALU_LAT=2 and check the whole occupancy window.
  task automatic do_op(input string tag, input logic [4:0] c, input logic [3:0] af,
                       input logic [3:0] prev, input logic [3:0] exp);
    op_valid  = 1'b1;
    op_cond   = c;
    alu_flags = af;
    #1;
    check({tag, " op_ready idle"}, {3'b0, op_ready}, 4'd1);
    tick();
    op_valid = 1'b0;
    check({tag, " busy T"}, {3'b0, busy}, 4'd1);
    check({tag, " op_ready T"}, {3'b0, op_ready}, 4'd0);
    check({tag, " flags T"}, flags_q, prev);
    tick();
    check({tag, " busy T+1"}, {3'b0, busy}, 4'd1);
    check({tag, " flags T+1"}, flags_q, prev);
    tick();
    check({tag, " flags T+2"}, flags_q, exp);
    check({tag, " busy T+2"}, {3'b0, busy}, 4'd0);
    $display("op %b alu_flags=%b -> flags_q=%b (expected %b)", c, af, flags_q, exp);
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst flags", flags_q, 4'b0000);
    check("rst busy", {3'b0, busy}, 4'd0);
    check("rst br_valid", {3'b0, br_valid}, 4'd0);
    check("rst br_taken", {3'b0, br_taken}, 4'd0);
    r = 1'b1;
    #1;
    check("rst op_ready", {3'b0, op_ready}, 4'd1);
    check("rst br_ready", {3'b0, br_ready}, 4'd1);

    // Reset mid-op: the in-flight op must be discarded
    tick();
    op_valid  = 1'b1;
    op_cond   = 5'b00101;
    alu_flags = 4'b1111;
    tick();
    op_valid = 1'b0;
    check("midrst busy", {3'b0, busy}, 4'd1);
    tick();
    r = 1'b0;
    #1;
    check("midrst async busy", {3'b0, busy}, 4'd0);
    check("midrst async flags", flags_q, 4'b0000);
    tick();
    r = 1'b1;
    #1;
    check("midrst op_ready", {3'b0, op_ready}, 4'd1);
    tick();
    tick();
    tick();
    check("midrst no commit", flags_q, 4'b0000);
    check("midrst busy after", {3'b0, busy}, 4'd0);
    $display("reset mid-op: flags_q=%b busy=%b", flags_q, busy);

    // Arithmetic commit and masks
    do_op("arith", 5'b00101, 4'b1011, 4'b0000, 4'b1011);
    do_op("set1111", 5'b00000, 4'b1111, 4'b1011, 4'b1111);
    do_op("mask0101", 5'b10001, 4'b0000, 4'b1111, 4'b1010);
    do_op("mask0111", 5'b01000, 4'b1111, 4'b1010, 4'b1111);
    do_op("mask0001", 5'b10000, 4'b0000, 4'b1111, 4'b1110);
    do_op("clr", 5'b00000, 4'b0000, 4'b1110, 4'b0000);
    do_op("unmapped", 5'b00010, 4'b1111, 4'b0000, 4'b0000);
    do_op("set0100", 5'b00110, 4'b0100, 4'b0000, 4'b0100);

    // Back-to-back branch queries on flags_q=0100 (S=1, O=0, Z=0, C=0)
    br_req  = 1'b1;
    br_cond = 3'b110;
    #1;
    check("br rdy", {3'b0, br_ready}, 4'd1);
    check("br op_ready blocked", {3'b0, op_ready}, 4'd0);
    tick();
    check("br S^O valid", {3'b0, br_valid}, 4'd1);
    check("br S^O taken", {3'b0, br_taken}, 4'd1);
    $display("branch 110 -> valid=%b taken=%b", br_valid, br_taken);
    br_cond = 3'b001;
    tick();
    check("br Z valid", {3'b0, br_valid}, 4'd1);
    check("br Z taken", {3'b0, br_taken}, 4'd0);
    $display("branch 001 -> valid=%b taken=%b", br_valid, br_taken);
    br_cond = 3'b000;
    tick();
    check("br always taken", {3'b0, br_taken}, 4'd1);
    $display("branch 000 -> valid=%b taken=%b", br_valid, br_taken);
    br_cond = 3'b011;
    tick();
    check("br C taken", {3'b0, br_taken}, 4'd0);
    $display("branch 011 -> valid=%b taken=%b", br_valid, br_taken);
    br_cond = 3'b101;
    tick();
    check("br S taken", {3'b0, br_taken}, 4'd1);
    $display("branch 101 -> valid=%b taken=%b", br_valid, br_taken);
    br_req = 1'b0;
    tick();
    check("br pulse end", {3'b0, br_valid}, 4'd0);
    check("br taken holds", {3'b0, br_taken}, 4'd1);

    // Arbitration: op and branch together in IDLE, branch wins
    op_valid  = 1'b1;
    op_cond   = 5'b00101;
    alu_flags = 4'b0001;
    br_req    = 1'b1;
    br_cond   = 3'b111;
    #1;
    check("arb op_ready", {3'b0, op_ready}, 4'd0);
    tick();
    br_req = 1'b0;
    #1;
    check("arb br_valid", {3'b0, br_valid}, 4'd1);
    check("arb br_taken O", {3'b0, br_taken}, 4'd0);
    check("arb op not taken", {3'b0, busy}, 4'd0);
    check("arb op_ready now", {3'b0, op_ready}, 4'd1);
    tick();
    op_valid = 1'b0;
    check("arb op accepted", {3'b0, busy}, 4'd1);
    $display("arbitration: branch first, op accepted next cycle busy=%b", busy);
    tick();
    // Final WAIT cycle of op 00101 with alu_flags=0001
    br_req  = 1'b1;
    br_cond = 3'b001;
    #1;
`ifdef FLAG_FWD_EN
    check("fwd br_ready", {3'b0, br_ready}, 4'd1);
    tick();
    br_req = 1'b0;
    check("fwd br_valid", {3'b0, br_valid}, 4'd1);
    check("fwd br_taken", {3'b0, br_taken}, 4'd1);
    check("fwd flags", flags_q, 4'b0001);
`else
    check("nofwd br_ready", {3'b0, br_ready}, 4'd0);
    tick();
    check("nofwd no pulse", {3'b0, br_valid}, 4'd0);
    check("nofwd flags", flags_q, 4'b0001);
    check("nofwd br_ready idle", {3'b0, br_ready}, 4'd1);
    tick();
    br_req = 1'b0;
    check("nofwd br_valid", {3'b0, br_valid}, 4'd1);
    check("nofwd br_taken", {3'b0, br_taken}, 4'd1);
`endif
    $display("final-cycle query: br_valid=%b br_taken=%b flags_q=%b", br_valid, br_taken, flags_q);
    tick();
    check("end busy", {3'b0, busy}, 4'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
